// File: rtl/img2col_pu_array_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : img2col_pkg
//  Purpose  : Shared defaults, drain FSM state type and the active-PU clamp
//             helper for the img2col PU window array.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package img2col_pkg;

   localparam int C_DATA_W = 16;
   localparam int C_K      = 5;
   localparam int C_WIN    = C_K * C_K;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // A request of zero PUs, or more PUs than exist, means "drain them all".
   function automatic int unsigned clamp_active(input int unsigned num_active,
                                                input int unsigned num_pu);
      if (num_active == 0 || num_active > num_pu) begin
         return num_pu;
      end
      return num_active;
   endfunction

endpackage
`default_nettype wire

// File: rtl/img2col_pu_array_window.sv
`default_nettype none
// ============================================================================
//  Module   : img2col_pu_window
//  Purpose  : One processing unit's K x K pixel window (row-major, element
//             e = row*K + col) with two-lane write, one-column left slide and
//             a flattened view of the stored window.
//  Ports    : clk, nrst          - clock, async active-high reset
//             wr_en_i            - lane 0 write (already address/PU checked)
//             wr_en1_i           - also write lane 1 at wr_addr_i+1
//             wr_addr_i          - lane 0 element address
//             wr_data0_i/1_i     - lane 0 / lane 1 pixel
//             slide_i            - shift every row one column left
//             win_o              - element e at [e*DATA_W +: DATA_W]
//  Revision : 1.0 - initial release
// ============================================================================
module img2col_pu_window
   import img2col_pkg::*;
#(
   parameter int DATA_W = C_DATA_W,
   parameter int K      = C_K,
   parameter int ADDR_W = 6
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     wr_en_i,
   input  logic                     wr_en1_i,
   input  logic [ADDR_W-1:0]        wr_addr_i,
   input  logic [DATA_W-1:0]        wr_data0_i,
   input  logic [DATA_W-1:0]        wr_data1_i,
   input  logic                     slide_i,
   output logic [K*K*DATA_W-1:0]    win_o
);

   localparam int WIN = K * K;

   logic [DATA_W-1:0] win_q [WIN];
   logic [DATA_W-1:0] win_d [WIN];

   // Slide is applied first, then the writes overwrite the shifted result,
   // so a same-cycle write always wins at its address (even column K-1).
   always_comb begin
      win_o = '0;
      for (int e = 0; e < WIN; e++) begin
         win_d[e] = win_q[e];
         if (slide_i) begin
            // The modulo keeps the right-neighbour index in range; the last
            // column takes zero and never uses it.
            win_d[e] = ((e % K) == K - 1) ? '0 : win_q[(e + 1) % WIN];
         end
         if (wr_en_i && (32'(wr_addr_i) == e)) begin
            win_d[e] = wr_data0_i;
         end
         // Lane 1 only lands when wr_addr_i+1 is a real element; a lane 1
         // past the end of the window has no matching e and is dropped.
         if (wr_en_i && wr_en1_i && (e > 0) && (32'(wr_addr_i) == e - 1)) begin
            win_d[e] = wr_data1_i;
         end
         win_o[e*DATA_W +: DATA_W] = win_q[e];
      end
   end

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         for (int e = 0; e < WIN; e++) begin
            win_q[e] <= '0;
         end
      end else begin
         win_q <= win_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/img2col_pu_array.sv
`default_nettype none
// ============================================================================
//  Module   : img2col_pu_array
//  Purpose  : Array of NUM_PU img2col windows. Host side writes pixels two
//             lanes per cycle and slides all windows; drain side streams each
//             active PU's flattened window through valid/ready, one per cycle.
//  Ports    : clk, nrst                      - clock, async active-high reset
//             wr_en, wr_en1, wr_pu, wr_addr,
//             wr_data0, wr_data1             - two-lane pixel write
//             slide                          - shift all windows left
//             start, num_active              - begin a drain of N PUs
//             out_valid, out_ready, out_data,
//             out_pu, out_last               - drain stream
//             busy, done, err                - status / pulses
//  Revision : 1.0 - initial release
// ============================================================================
module img2col_pu_array
   import img2col_pkg::*;
#(
   parameter int NUM_PU = 28,
   parameter int DATA_W = C_DATA_W,
   parameter int K      = C_K,
   parameter int PU_W   = 6,
   parameter int ADDR_W = 6
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     wr_en,
   input  logic                     wr_en1,
   input  logic [PU_W-1:0]          wr_pu,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data0,
   input  logic [DATA_W-1:0]        wr_data1,
   input  logic                     slide,
   input  logic                     start,
   input  logic [PU_W-1:0]          num_active,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [K*K*DATA_W-1:0]    out_data,
   output logic [PU_W-1:0]          out_pu,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int WIN    = K * K;
   localparam int FLAT_W = WIN * DATA_W;

   state_t              state_q, state_d;
   logic [PU_W-1:0]     n_q, n_d;
   logic [PU_W-1:0]     pu_q, pu_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [FLAT_W-1:0]   data_q, data_d;

   logic [FLAT_W-1:0]   w_win [NUM_PU];
   logic [NUM_PU-1:0]   w_pu_we;
   logic                w_idle;
   logic                w_wr_legal;
   logic [PU_W-1:0]     w_n_start;
   logic [PU_W-1:0]     w_pu_next;
   logic [FLAT_W-1:0]   w_sel_data;

   assign w_idle     = (state_q == IDLE);
   assign w_wr_legal = (32'(wr_pu) < NUM_PU) && (32'(wr_addr) < WIN);
   assign w_n_start  = PU_W'(clamp_active(32'(num_active), NUM_PU));

   // Windows only change in IDLE, so the registered out_data copy is the
   // sole path from window storage to the consumer during a drain.
   for (genvar p = 0; p < NUM_PU; p++) begin : g_pu
      assign w_pu_we[p] = w_idle && wr_en && w_wr_legal && (32'(wr_pu) == p);

      img2col_pu_window #(
         .DATA_W (DATA_W),
         .K      (K),
         .ADDR_W (ADDR_W)
      ) u_window (
         .clk        (clk),
         .nrst       (nrst),
         .wr_en_i    (w_pu_we[p]),
         .wr_en1_i   (wr_en1),
         .wr_addr_i  (wr_addr),
         .wr_data0_i (wr_data0),
         .wr_data1_i (wr_data1),
         .slide_i    (w_idle && slide),
         .win_o      (w_win[p])
      );
   end

   // PU that the output register loads next: 0 on start, else the successor.
   assign w_pu_next = w_idle ? '0 : (pu_q + PU_W'(1));

   always_comb begin
      w_sel_data = '0;
      for (int p = 0; p < NUM_PU; p++) begin
         if (PU_W'(p) == w_pu_next) begin
            w_sel_data = w_win[p];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      pu_d    = pu_q;
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_en && !w_wr_legal) begin
               err_d = 1'b1;
            end
            if (start) begin
               if (wr_en || slide) begin
                  err_d = 1'b1;
               end else begin
                  state_d = DRAIN;
                  n_d     = w_n_start;
                  pu_d    = '0;
                  valid_d = 1'b1;
                  last_d  = (w_n_start == PU_W'(1));
                  data_d  = w_sel_data;
               end
            end
         end
         DRAIN: begin
            if (wr_en || slide || start) begin
               err_d = 1'b1;
            end
            if (valid_q && out_ready) begin
               if (last_q) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  pu_d   = w_pu_next;
                  data_d = w_sel_data;
                  last_d = (w_pu_next == n_q - PU_W'(1));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state_q <= IDLE;
         n_q     <= '0;
         pu_q    <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         pu_q    <= pu_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_pu    = pu_q;
   assign out_last  = last_q;
   assign busy      = (state_q == DRAIN);
   assign done      = done_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_img2col_pu_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_img2col_pu_array
//  Purpose  : Self-checking bench for img2col_pu_array: directed write/slide
//             vectors with a reference window model, drains with and without
//             back-pressure, illegal requests and mid-drain reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_img2col_pu_array;

   localparam int NUM_PU = 28;
   localparam int DATA_W = 16;
   localparam int K      = 5;
   localparam int WIN    = K * K;
   localparam int PU_W   = 6;
   localparam int ADDR_W = 6;

   logic                  clk;
   logic                  nrst;
   logic                  wr_en, wr_en1, slide, start, out_ready;
   logic [PU_W-1:0]       wr_pu, num_active;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data0, wr_data1;
   logic                  out_valid, out_last, busy, done, err;
   logic [WIN*DATA_W-1:0] out_data;
   logic [PU_W-1:0]       out_pu;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DATA_W-1:0]     m   [NUM_PU][WIN];
   logic [WIN*DATA_W-1:0] got [NUM_PU];

   typedef struct {
      bit we; bit e1; bit sl; bit st;
      int pu; int addr; int d0; int d1;
      bit exp_err;
   } wv_t;

   typedef struct {
      int pu; int e; int exp_val;
   } sv_t;

   img2col_pu_array #(
      .NUM_PU (NUM_PU), .DATA_W (DATA_W), .K (K), .PU_W (PU_W), .ADDR_W (ADDR_W)
   ) dut (
      .clk (clk), .nrst (nrst),
      .wr_en (wr_en), .wr_en1 (wr_en1), .wr_pu (wr_pu), .wr_addr (wr_addr),
      .wr_data0 (wr_data0), .wr_data1 (wr_data1),
      .slide (slide), .start (start), .num_active (num_active),
      .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
      .out_pu (out_pu), .out_last (out_last),
      .busy (busy), .done (done), .err (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   function automatic logic [DATA_W-1:0] ge(input int p, input int e);
      return got[p][e*DATA_W +: DATA_W];
   endfunction

   task automatic model_clear();
      for (int p = 0; p < NUM_PU; p++)
         for (int e = 0; e < WIN; e++) m[p][e] = '0;
   endtask

   task automatic model_slide();
      for (int p = 0; p < NUM_PU; p++)
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
               m[p][r*K+c] = (c < K - 1) ? m[p][r*K+c+1] : '0;
   endtask

   // One IDLE cycle of host activity; the model applies slide, then write.
   task automatic wr_op(input wv_t v);
      @(negedge clk);
      wr_en = v.we; wr_en1 = v.e1; slide = v.sl; start = v.st;
      wr_pu = PU_W'(v.pu); wr_addr = ADDR_W'(v.addr);
      wr_data0 = DATA_W'(v.d0); wr_data1 = DATA_W'(v.d1); num_active = '0;
      if (v.sl) model_slide();
      if (v.we && v.pu < NUM_PU && v.addr < WIN) begin
         m[v.pu][v.addr] = DATA_W'(v.d0);
         if (v.e1 && v.addr + 1 < WIN) m[v.pu][v.addr+1] = DATA_W'(v.d1);
      end
      @(negedge clk);
      wr_en = 0; wr_en1 = 0; slide = 0; start = 0;
      chk("err_idle", err, v.exp_err);
      if (v.st) chk("start_ignored_busy", busy, 0);
   endtask

   task automatic cmp_model(input int n);
      for (int p = 0; p < n; p++) begin
         bit ok = 1;
         n_chk++;
         for (int e = 0; e < WIN; e++) begin
            if (ok && ge(p, e) !== m[p][e]) begin
               ok = 0;
               $display("FAIL window pu%0d elem%0d: got %0h expected %0h", p, e, ge(p, e), m[p][e]);
            end
         end
         if (!ok) n_fail++;
      end
   endtask

   // Drain n_exp beats; stall applies ready pattern 1,0,0,1; inj drives
   // wr_en, slide, start on consecutive cycles mid-drain.
   task automatic drain(input int na, input int n_exp, input bit stall, input bit inj);
      int cyc, beats;
      bit r, held;
      logic [PU_W-1:0]       hpu;
      logic [WIN*DATA_W-1:0] hdat;
      @(negedge clk);
      start = 1; num_active = PU_W'(na);
      @(negedge clk);
      start = 0;
      chk("busy_on_start", busy, 1);
      chk("valid_on_start", out_valid, 1);
      beats = 0; held = 0; cyc = 0; hpu = '0; hdat = '0;
      while (beats < n_exp && cyc < 400) begin
         if (held) begin
            chk("stall_pu", out_pu, hpu);
            chk("stall_data", out_data == hdat, 1);
         end
         if (inj) begin
            wr_en = (cyc == 1); slide = (cyc == 2); start = (cyc == 3);
            if (cyc >= 2 && cyc <= 4) chk("err_in_drain", err, 1);
         end
         r = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
         out_ready = r;
         held = 0;
         if (out_valid && r) begin
            chk("beat_pu", out_pu, beats);
            chk("beat_last", out_last, beats == n_exp - 1);
            got[beats] = out_data;
            beats++;
         end else if (out_valid) begin
            held = 1; hpu = out_pu; hdat = out_data;
         end else begin
            chk("valid_hold", out_valid, 1);
         end
         @(negedge clk);
         cyc++;
      end
      wr_en = 0; slide = 0; start = 0; out_ready = 0;
      chk("drain_beats", beats, n_exp);
      chk("done_pulse", done, 1);
      chk("busy_end", busy, 0);
      chk("valid_end", out_valid, 0);
      @(negedge clk);
      chk("done_single", done, 0);
   endtask

   initial begin
      wv_t tab[5];
      sv_t spot[11];

      nrst = 1; wr_en = 0; wr_en1 = 0; slide = 0; start = 0; out_ready = 0;
      wr_pu = '0; wr_addr = '0; wr_data0 = '0; wr_data1 = '0; num_active = '0;
      model_clear();

      // Reset state
      repeat (2) @(negedge clk);
      nrst = 0;
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_last", out_last, 0);
      chk("rst_pu", out_pu, 0);
      chk("rst_data", out_data == '0, 1);

      // PU3 loaded two lanes at a time, data = 100+addr; lane 1 at 24 dropped
      for (int a = 0; a < WIN; a += 2) wr_op('{1, 1, 0, 0, 3, a, 100 + a, 101 + a, 0});
      drain(4, 4, 0, 0);
      for (int e = 0; e < WIN; e++) chk("pu3_elem", ge(3, e), 100 + e);
      cmp_model(4);

      // Lane 1 past the window end must not wrap to element 0
      wr_op('{1, 1, 0, 0, 0, 24, 'h55, 'h66, 0});
      drain(1, 1, 0, 0);
      chk("pu0_e24", ge(0, 24), 'h55);
      chk("pu0_e0_nowrap", ge(0, 0), 0);

      // PU1 element e = e, slide, then slide + write 7 at row0 col4
      for (int a = 0; a < WIN; a += 2) wr_op('{1, 1, 0, 0, 1, a, a, a + 1, 0});
      wr_op('{0, 0, 1, 0, 0, 0, 0, 0, 0});
      wr_op('{1, 0, 1, 0, 1, 4, 7, 0, 0});
      drain(0, NUM_PU, 1, 0);
      spot[0]  = '{1, 0, 2};     spot[1]  = '{1, 2, 4};
      spot[2]  = '{1, 3, 0};     spot[3]  = '{1, 4, 7};
      spot[4]  = '{1, 5, 7};     spot[5]  = '{1, 9, 0};
      spot[6]  = '{1, 20, 22};   spot[7]  = '{1, 22, 24};
      spot[8]  = '{3, 0, 102};   spot[9]  = '{3, 4, 0};
      spot[10] = '{0, 22, 'h55};
      for (int i = 0; i < 11; i++) chk("spot", ge(spot[i].pu, spot[i].e), spot[i].exp_val);
      cmp_model(NUM_PU);

      // Illegal and mixed requests in IDLE
      tab[0] = '{1, 0, 0, 0, 28, 0, 'h1, 0, 1};
      tab[1] = '{1, 0, 0, 0, 0, 25, 'h2, 0, 1};
      tab[2] = '{1, 1, 0, 1, 2, 3, 'h11, 'h22, 1};
      tab[3] = '{0, 0, 1, 1, 0, 0, 0, 0, 1};
      tab[4] = '{1, 1, 0, 0, 5, 10, 'hA, 'hB, 0};
      for (int i = 0; i < 5; i++) wr_op(tab[i]);

      // Requests during DRAIN are ignored and flagged
      wr_pu = '0; wr_addr = '0; wr_data0 = 16'hBEEF; wr_data1 = 16'hBEEF;
      drain(6, 6, 0, 1);
      cmp_model(6);
      chk("pu2_e2", ge(2, 2), 'h11);
      chk("pu5_e11", ge(5, 11), 'hB);

      // Reset asserted on beat 2 of a drain
      @(negedge clk);
      start = 1; num_active = '0;
      @(negedge clk);
      start = 0; out_ready = 1;
      @(negedge clk);
      @(negedge clk);
      chk("pu_before_rst", out_pu, 2);
      #1 nrst = 1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_pu", out_pu, 0);
      @(negedge clk);
      nrst = 0; out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("arst_no_done", done, 0);
      end
      model_clear();
      drain(0, NUM_PU, 0, 0);
      cmp_model(NUM_PU);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/img2col_pu_array.md
Name: img2col_pu_array

Overview:
- Parametrised img2col window array: NUM_PU processing units, each holding one K x K pixel window.
- Host side loads pixels two lanes per cycle and can slide all windows one column left for horizontal reuse across rounds.
- Drain side streams each active PU's flattened window out through a valid/ready handshake, one PU per cycle.
- Sits between the AXI input unpacker and the systolic MAC array; replaces the fixed 28-PU, 5x5, PU_No-selected window vector.

Parameters:
NUM_PU, 28, number of processing units (1..64)
DATA_W, 16, pixel width in bits
K, 5, kernel dimension (2..7); WIN = K*K elements per window
PU_W, 6, width of PU index (>= clog2(NUM_PU+1))
ADDR_W, 6, width of window address (>= clog2(WIN))

Ports:
clk  in  1  clock, all logic on rising edge
nrst  in  1  asynchronous reset, active-high (1 = reset)
wr_en  in  1  write pixel lane 0
wr_en1  in  1  also write lane 1 (qualified by wr_en)
wr_pu  in  PU_W  target PU
wr_addr  in  ADDR_W  window address = row*K + col for lane 0
wr_data0  in  DATA_W  lane 0 pixel, written at wr_addr
wr_data1  in  DATA_W  lane 1 pixel, written at wr_addr+1
slide  in  1  pulse: shift every window one column left
start  in  1  pulse: begin draining
num_active  in  PU_W  number of PUs to drain
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts
out_data  out  WIN*DATA_W  flattened window, element e at bits [e*DATA_W +: DATA_W]
out_pu  out  PU_W  index of PU in out_data
out_last  out  1  out_data is final PU of drain
busy  out  1  in DRAIN state
done  out  1  one-cycle pulse after final handshake
err  out  1  one-cycle pulse on illegal request

Behaviour:
- Reset (nrst=1, asynchronous): all window registers 0; state IDLE; out_valid, out_last, busy, done, err = 0; out_data = 0; out_pu = 0; counters 0.
- FSM states:
  - IDLE: accepts wr_en, slide, start.
  - DRAIN: streams PUs 0..N-1.
- Write (IDLE):
  - wr_en=1 with wr_pu < NUM_PU and wr_addr < WIN stores wr_data0 at the next edge.
  - Lane 1 is stored at wr_addr+1 only if wr_en1=1 and wr_addr+1 < WIN; otherwise lane 1 is silently dropped.
  - wr_pu >= NUM_PU or wr_addr >= WIN: no write; err pulses.
- Slide (IDLE):
  - Every PU: column c <= column c+1 for c = 0..K-2; column K-1 <= 0.
  - slide and wr_en in the same cycle: slide applies first, then the write lands in the shifted window. The write wins at its address, including column K-1.
- Start (IDLE):
  - N = num_active, with 0 and values > NUM_PU treated as NUM_PU. N is latched at start.
  - start with wr_en or slide in the same cycle: start ignored, write/slide still applied, err pulses.
  - Accepted start: next cycle busy=1, out_valid=1, out_pu=0, out_data = PU0 window, out_last = (N==1).
- Handshake (DRAIN):
  - While out_valid && !out_ready, out_data, out_pu and out_last are held stable.
  - On handshake for PU i < N-1: next cycle out_pu=i+1, out_data = PU i+1 window, out_valid stays 1. Throughput is one PU per cycle.
  - On handshake with out_last=1: next cycle out_valid=0, out_last=0, busy=0, done=1, state IDLE.
- Illegal in DRAIN: wr_en, slide or start are ignored (windows unchanged) and err pulses.
- out_data is a registered copy, so windows are never modified while draining.
- Reset asserted mid-drain: immediate return to reset values; no done pulse.
- err and done are single-cycle pulses; err fires once per offending cycle.

Decomposition:
- Package img2col_pkg holds:
  - defaults DATA_W, K, WIN
  - state typedef enum {IDLE, DRAIN}
  - helper function clamp_active(num_active, NUM_PU)
- Sub-module img2col_pu_window: one PU's WIN registers, two-lane write, column slide, flattened window output. The top generates NUM_PU instances plus the FSM, drain counter and output register.

Test Plan:
- Load PU3 addr 0..24 via two lanes (data = 100+addr), start with num_active=4, out_ready=1 -> four consecutive beats out_pu 0..3; beat 3 holds elements 100..124; out_last on beat 3; done one cycle after.
- wr_addr=24 with wr_en1=1 on PU0 -> element 24 written; no wrap to element 0; err stays 0.
- PU1 element e = e, slide, then write 7 at addr 4 (row0, col4) same cycle as a second slide -> column 0 holds original col2, col4 row0 = 7, other col4 entries 0.
- Drain with out_ready toggling 1,0,0,1 -> out_data and out_pu stable during stalls; no beat lost or duplicated; 28 beats for num_active=0.
- wr_en, slide and start during DRAIN, plus wr_pu=28 in IDLE -> err pulse each time; windows unchanged; drain sequence unaffected.
- nrst=1 on beat 2 of a drain -> out_valid=0 and busy=0 asynchronously; all windows read 0 on the next drain; no done pulse.
